pc_uart_rx: RTL and testbench

Parametrised successor to the fixed 8N1, 115200-baud pinacolada UART receiver. Adds configurable baud divisor, data width, parity and stop bits, plus 16x oversampling with 3-sample majority vote. Detects parity, framing and overrun errors. Sits between the board rx pin and the pinacolada bus-side peripheral logic, delivering words through a small show-ahead FIFO with a valid/ready handshake.

---
 rtl/pc_uart_pkg.sv | 26 ++
 rtl/pc_uart_rx_fifo.sv | 65 ++++++
 rtl/pc_uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_pc_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_uart_pkg.sv
// Shared constants, state encoding and helpers for the pinacolada UART receiver.
package pc_uart_pkg;

  localparam int         OS_RATE   = 16;
  localparam logic [3:0] SMP_FIRST = 4'd7;
  localparam logic [3:0] SMP_MID   = 4'd8;
  localparam logic [3:0] SMP_LAST  = 4'd9;
  localparam logic [3:0] OS_LAST   = 4'(OS_RATE - 1);

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pc_uart_rx_fifo.sv
// Show-ahead receive FIFO; a push to a full FIFO is accepted only alongside a pop.
module pc_uart_rx_fifo
  import pc_uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage and pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_level == LW'(0));
  assign full  = (r_level == LW'(DEPTH));
  assign level = r_level;

endmodule

// File: rtl/pc_uart_rx.sv
// Parametrised UART receiver: 16x oversampling with 3-sample majority vote,
// parity/framing/overrun detection and a show-ahead output FIFO.
module pc_uart_rx
  import pc_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              rx_parity_err,
  output logic                              rx_frame_err,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic                              overrun,
  input  logic                              err_clr,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int OS_DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
  localparam int DIV_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int EW         = DATA_BITS + 2;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  function automatic logic par_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY == PAR_ODD) return ~x;
    else                   return x;
  endfunction

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [DIV_W-1:0]     r_div;
  rx_state_t            r_state;
  logic [3:0]           r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_smp_a;
  logic                 r_smp_b;
  logic                 r_pe;
  logic                 r_fe;
  logic                 r_push;
  logic [EW-1:0]        r_push_word;
  logic                 r_overrun;

  logic                 w_start_go;
  logic                 w_os_tick;
  logic                 w_decide;
  logic                 w_win_end;
  logic                 w_bit;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [EW-1:0]        w_head;
  logic [LW-1:0]        w_level;

  // Two-flop synchroniser; idles high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_start_go = (r_state == S_IDLE) & ~r_rx_s;
  assign w_os_tick  = (r_div == DIV_W'(OS_DIV - 1));

  // Oversample tick divider, re-phased to the detected start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_start_go || w_os_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_decide  = w_os_tick & (r_os_cnt == SMP_LAST);
  assign w_win_end = w_os_tick & (r_os_cnt == OS_LAST);
  assign w_bit     = maj3(r_smp_a, r_smp_b, r_rx_s);

  // Receive FSM with sampling counters and the registered push request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_os_cnt    <= 4'd0;
      r_bit_cnt   <= 4'd0;
      r_shift     <= '0;
      r_smp_a     <= 1'b0;
      r_smp_b     <= 1'b0;
      r_pe        <= 1'b0;
      r_fe        <= 1'b0;
      r_push      <= 1'b0;
      r_push_word <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_os_tick && (r_state != S_IDLE)) begin
        r_os_cnt <= r_os_cnt + 4'd1;
        if (r_os_cnt == SMP_FIRST) r_smp_a <= r_rx_s;
        if (r_os_cnt == SMP_MID)   r_smp_b <= r_rx_s;
      end
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state   <= S_START;
            r_os_cnt  <= 4'd0;
            r_bit_cnt <= 4'd0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
          end
        end
        S_START: begin
          if (w_decide && w_bit) r_state <= S_IDLE;
          else if (w_win_end)    r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_decide) begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          if (w_win_end && (r_bit_cnt == 4'(DATA_BITS))) begin
            r_bit_cnt <= 4'd0;
            r_state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_decide)  r_pe    <= par_bad(r_shift, w_bit);
          if (w_win_end) r_state <= S_STOP;
        end
        S_STOP: begin
          // Leave on the last stop decision so an early start edge is caught
          if (w_decide) begin
            if (!w_bit) r_fe <= 1'b1;
            if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
              r_push      <= 1'b1;
              r_push_word <= {r_shift, r_pe, r_fe | ~w_bit};
              r_state     <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop = rx_ready & ~w_empty;

  pc_uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_push),
    .pop   (w_pop),
    .din   (r_push_word),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // Sticky overrun; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (r_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (err_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign rx_data       = w_head[EW-1:2];
  assign rx_parity_err = w_head[1];
  assign rx_frame_err  = w_head[0];
  assign rx_valid      = ~w_empty;
  assign fifo_level    = w_level;
  assign overrun       = r_overrun;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_pc_uart_rx.sv
// Directed bench: three receiver instances (8N1, 7E1, 8N2) at 64 clk per bit.
module tb_pc_uart_rx;

  localparam int CLK_HZ  = 50000000;
  localparam int BAUD    = CLK_HZ / 64;
  localparam int BIT_CLK = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic       rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  logic       clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic       pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;
  logic       val_a, val_b, val_c, ovr_a, ovr_b, ovr_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] lvl_a, lvl_b, lvl_c;

  int n_checks = 0;
  int n_fail   = 0;

  pc_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_parity_err(pe_a),
    .rx_frame_err(fe_a), .rx_valid(val_a), .rx_ready(rdy_a), .overrun(ovr_a),
    .err_clr(clr_a), .busy(busy_a), .fifo_level(lvl_a));

  pc_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_parity_err(pe_b),
    .rx_frame_err(fe_b), .rx_valid(val_b), .rx_ready(rdy_b), .overrun(ovr_b),
    .err_clr(clr_b), .busy(busy_b), .fifo_level(lvl_b));

  pc_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_c), .rx_data(data_c), .rx_parity_err(pe_c),
    .rx_frame_err(fe_c), .rx_valid(val_c), .rx_ready(rdy_c), .overrun(ovr_c),
    .err_clr(clr_c), .busy(busy_c), .fifo_level(lvl_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int line, input logic b);
    case (line)
      0:       rx_a = b;
      1:       rx_b = b;
      default: rx_c = b;
    endcase
  endtask

  // bits[0] is the start bit; each bit held one bit period, line idles high after
  task automatic drive_bits(input int line, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_rx(line, bits[i]);
      repeat (BIT_CLK - 1) @(negedge clk);
    end
    @(negedge clk);
    set_rx(line, 1'b1);
  endtask

  task automatic wait_valid(input int line, input int budget, input string tag);
    logic v;
    int   k;
    k = 0;
    v = 1'b0;
    while (!v && k < budget) begin
      @(negedge clk);
      v = (line == 0) ? val_a : (line == 1) ? val_b : val_c;
      k++;
    end
    check(tag, {31'd0, v}, 32'd1);
  endtask

  task automatic pop(input int line);
    @(negedge clk);
    case (line)
      0:       rdy_a = 1'b1;
      1:       rdy_b = 1'b1;
      default: rdy_c = 1'b1;
    endcase
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    rdy_c = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_valid"}, {31'd0, val_a}, 32'd0);
    check({tag, "_data"}, {24'd0, data_a}, 32'd0);
    check({tag, "_pe"}, {31'd0, pe_a}, 32'd0);
    check({tag, "_fe"}, {31'd0, fe_a}, 32'd0);
    check({tag, "_ovr"}, {31'd0, ovr_a}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_lvl"}, {29'd0, lvl_a}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_a_zero("rst");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 0xA5 and pop
    drive_bits(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    wait_valid(0, 8, "t1_valid");
    check("t1_data", {24'd0, data_a}, 32'hA5);
    check("t1_pe", {31'd0, pe_a}, 32'd0);
    check("t1_fe", {31'd0, fe_a}, 32'd0);
    check("t1_lvl", {29'd0, lvl_a}, 32'd1);
    pop(0);
    check("t1_pop_valid", {31'd0, val_a}, 32'd0);
    check("t1_pop_lvl", {29'd0, lvl_a}, 32'd0);

    // 24-clk glitch is rejected
    @(negedge clk);
    rx_a = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_busy_hi", {31'd0, busy_a}, 32'd1);
    repeat (14) @(negedge clk);
    rx_a = 1'b1;
    repeat (80) @(negedge clk);
    check("t2_busy_lo", {31'd0, busy_a}, 32'd0);
    check("t2_valid", {31'd0, val_a}, 32'd0);

    // 7E1: 0x03 has even ones, so parity bit 1 is wrong, 0 is right
    drive_bits(1, {6'd0, 1'b1, 1'b1, 7'h03, 1'b0}, 10);
    wait_valid(1, 8, "t3a_valid");
    check("t3a_data", {25'd0, data_b}, 32'h03);
    check("t3a_pe", {31'd0, pe_b}, 32'd1);
    check("t3a_fe", {31'd0, fe_b}, 32'd0);
    pop(1);
    drive_bits(1, {6'd0, 1'b1, 1'b0, 7'h03, 1'b0}, 10);
    wait_valid(1, 8, "t3b_valid");
    check("t3b_data", {25'd0, data_b}, 32'h03);
    check("t3b_pe", {31'd0, pe_b}, 32'd0);
    pop(1);
    check("t3_lvl", {29'd0, lvl_b}, 32'd0);

    // Framing errors: 8N1 stop low, 8N2 second stop low, 8N2 clean
    drive_bits(0, {6'd0, 1'b0, 8'h3C, 1'b0}, 10);
    wait_valid(0, 8, "t4a_valid");
    check("t4a_data", {24'd0, data_a}, 32'h3C);
    check("t4a_fe", {31'd0, fe_a}, 32'd1);
    check("t4a_pe", {31'd0, pe_a}, 32'd0);
    pop(0);
    repeat (150) @(negedge clk);
    check("t4a_no_extra", {31'd0, val_a}, 32'd0);
    check("t4a_idle", {31'd0, busy_a}, 32'd0);
    drive_bits(2, {5'd0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    wait_valid(2, 8, "t4b_valid");
    check("t4b_data", {24'd0, data_c}, 32'h3C);
    check("t4b_fe", {31'd0, fe_c}, 32'd1);
    pop(2);
    repeat (150) @(negedge clk);
    drive_bits(2, {5'd0, 1'b1, 1'b1, 8'hC3, 1'b0}, 11);
    wait_valid(2, 8, "t4c_valid");
    check("t4c_data", {24'd0, data_c}, 32'hC3);
    check("t4c_fe", {31'd0, fe_c}, 32'd0);
    pop(2);

    // Overrun with a full FIFO, then drain in order and clear
    for (int k = 1; k <= 5; k++) begin
      drive_bits(0, {6'd0, 1'b1, 8'(k), 1'b0}, 10);
    end
    repeat (10) @(negedge clk);
    check("t5_lvl", {29'd0, lvl_a}, 32'd4);
    check("t5_ovr", {31'd0, ovr_a}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t5_pop%0d", k), {24'd0, data_a}, 32'(k));
      pop(0);
    end
    check("t5_empty", {31'd0, val_a}, 32'd0);
    @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("t5_clr", {31'd0, ovr_a}, 32'd0);

    // Reset during data bit 3 of 0xFF, then a clean 0x5A
    @(negedge clk);
    rx_a = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * BIT_CLK + 32) @(negedge clk);
    check("t6_busy_pre", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_a_zero("t6_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    drive_bits(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10);
    wait_valid(0, 8, "t6_valid");
    check("t6_data", {24'd0, data_a}, 32'h5A);
    check("t6_pe", {31'd0, pe_a}, 32'd0);
    check("t6_fe", {31'd0, fe_a}, 32'd0);
    check("t6_lvl", {29'd0, lvl_a}, 32'd1);
    pop(0);
    repeat (200) @(negedge clk);
    check("t6_one_word", {29'd0, lvl_a}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
